// File: rtl/register_file_if.sv
// register_file_if: decoder/ROB facing signals of the architectural register file.
// The decoder and ROB side use the master modport, the register file the slave.
interface register_file_if;
   logic        flush;
   logic        rename_en;
   logic [4:0]  rename_regid;
   logic [4:0]  rename_vregid;
   logic        writeback_en;
   logic [4:0]  writeback_id;
   logic [4:0]  writeback_dependency;
   logic [31:0] writeback_val;
   logic [4:0]  query_regid1;
   logic [4:0]  query_regid2;
   logic        query_busy1;
   logic [4:0]  query_vregid1;
   logic [31:0] query_val1;
   logic        query_busy2;
   logic [4:0]  query_vregid2;
   logic [31:0] query_val2;

   modport master (
      output flush, rename_en, rename_regid, rename_vregid,
      output writeback_en, writeback_id, writeback_dependency, writeback_val,
      output query_regid1, query_regid2,
      input  query_busy1, query_vregid1, query_val1,
      input  query_busy2, query_vregid2, query_val2
   );

   modport slave (
      input  flush, rename_en, rename_regid, rename_vregid,
      input  writeback_en, writeback_id, writeback_dependency, writeback_val,
      input  query_regid1, query_regid2,
      output query_busy1, query_vregid1, query_val1,
      output query_busy2, query_vregid2, query_val2
   );
endinterface

// File: rtl/register_file.sv
// register_file: 32 x 32-bit architectural registers, each with a busy bit and
// the ROB index of its newest in-flight producer. Register 0 is hardwired zero.
// Query ports are combinational and bypass a same-cycle matching commit.
module register_file (
   input logic            clk,
   input logic            rst,
   register_file_if.slave bus
);

   logic [31:0] r_val [32];
   logic [31:0] r_busy;
   logic [4:0]  r_tag [32];

   logic        w_wb_valid;
   logic        w_ren_valid;
   logic        w_wb_clear;
   logic [37:0] w_q1;
   logic [37:0] w_q2;

   // Resolve one query port; result packed as {busy, vregid, val}.
   function automatic logic [37:0] f_query(
      input logic [4:0]  regid,
      input logic        busy,
      input logic [4:0]  tag,
      input logic [31:0] val,
      input logic        wb_en,
      input logic [4:0]  wb_id,
      input logic [4:0]  wb_dep,
      input logic [31:0] wb_val
   );
      logic [37:0] res;
      if (regid == 5'd0) begin
         res = {1'b0, 5'd0, 32'd0};
      end else if (!busy) begin
         res = {1'b0, 5'd0, val};
      end else if (wb_en && (wb_id == regid) && (wb_dep == tag)) begin
         // producer commits right now: forward its value
         res = {1'b0, 5'd0, wb_val};
      end else begin
         res = {1'b1, tag, val};
      end
      return res;
   endfunction

   // Decode which updates take effect at the next edge.
   always_comb begin
      w_wb_valid  = bus.writeback_en && (bus.writeback_id != 5'd0);
      w_ren_valid = bus.rename_en && (bus.rename_regid != 5'd0) && !bus.flush;
      // only the newest producer may clear busy, and a same-cycle rename wins
      w_wb_clear  = w_wb_valid
                    && r_busy[bus.writeback_id]
                    && (r_tag[bus.writeback_id] == bus.writeback_dependency)
                    && !(bus.rename_en && (bus.rename_regid == bus.writeback_id));
   end

   // Register values: committed results land unconditionally, even during flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_val[i] <= 32'd0;
         end
      end else if (w_wb_valid) begin
         r_val[bus.writeback_id] <= bus.writeback_val;
      end
   end

   // Busy bits and rename tags: flush drops every pending rename.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            r_tag[i] <= 5'd0;
         end
      end else if (bus.flush) begin
         r_busy <= 32'd0;
      end else begin
         if (w_wb_clear) begin
            r_busy[bus.writeback_id] <= 1'b0;
         end
         if (w_ren_valid) begin
            r_busy[bus.rename_regid] <= 1'b1;
            r_tag[bus.rename_regid]  <= bus.rename_vregid;
         end
      end
   end

   // Combinational operand lookup for both source ports.
   always_comb begin
      w_q1 = f_query(bus.query_regid1, r_busy[bus.query_regid1], r_tag[bus.query_regid1],
                     r_val[bus.query_regid1], bus.writeback_en, bus.writeback_id,
                     bus.writeback_dependency, bus.writeback_val);
      w_q2 = f_query(bus.query_regid2, r_busy[bus.query_regid2], r_tag[bus.query_regid2],
                     r_val[bus.query_regid2], bus.writeback_en, bus.writeback_id,
                     bus.writeback_dependency, bus.writeback_val);
   end

   assign {bus.query_busy1, bus.query_vregid1, bus.query_val1} = w_q1;
   assign {bus.query_busy2, bus.query_vregid2, bus.query_val2} = w_q2;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed table of per-cycle vectors for the key scenarios,
// then randomized traffic checked against an array-based register model.
module tb_register_file;

   logic clk;
   logic rst;

   register_file_if u_if ();

   register_file u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        re;
      logic [4:0]  rid;
      logic [4:0]  rv;
      logic        we;
      logic [4:0]  wid;
      logic [4:0]  wd;
      logic [31:0] wv;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic        eb1;
      logic [4:0]  ev1;
      logic [31:0] ex1;
      logic        eb2;
      logic [4:0]  ev2;
      logic [31:0] ex2;
   } vec_t;

   // reference model state
   logic [31:0] m_val [32];
   logic        m_busy [32];
   logic [4:0]  m_tag [32];

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl [30];

   function automatic vec_t mk(int fl, int re, int rid, int rv, int we, int wid, int wd,
                               logic [31:0] wv, int q1, int q2,
                               int eb1, int ev1, logic [31:0] ex1,
                               int eb2, int ev2, logic [31:0] ex2);
      vec_t v;
      v.fl = 1'(fl);   v.re = 1'(re);   v.rid = 5'(rid); v.rv = 5'(rv);
      v.we = 1'(we);   v.wid = 5'(wid); v.wd = 5'(wd);   v.wv = wv;
      v.q1 = 5'(q1);   v.q2 = 5'(q2);
      v.eb1 = 1'(eb1); v.ev1 = 5'(ev1); v.ex1 = ex1;
      v.eb2 = 1'(eb2); v.ev2 = 5'(ev2); v.ex2 = ex2;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      u_if.flush                = v.fl;
      u_if.rename_en            = v.re;
      u_if.rename_regid         = v.rid;
      u_if.rename_vregid        = v.rv;
      u_if.writeback_en         = v.we;
      u_if.writeback_id         = v.wid;
      u_if.writeback_dependency = v.wd;
      u_if.writeback_val        = v.wv;
      u_if.query_regid1         = v.q1;
      u_if.query_regid2         = v.q2;
   endtask

   // Architectural effect of one clock edge, applied rule by rule.
   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 5'd0;
         end
      end else begin
         if (u_if.writeback_en && u_if.writeback_id != 5'd0)
            m_val[u_if.writeback_id] = u_if.writeback_val;
         if (u_if.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else begin
            if (u_if.writeback_en && u_if.writeback_id != 5'd0 &&
                m_busy[u_if.writeback_id] &&
                m_tag[u_if.writeback_id] == u_if.writeback_dependency &&
                !(u_if.rename_en && u_if.rename_regid == u_if.writeback_id))
               m_busy[u_if.writeback_id] = 1'b0;
            if (u_if.rename_en && u_if.rename_regid != 5'd0) begin
               m_busy[u_if.rename_regid] = 1'b1;
               m_tag[u_if.rename_regid]  = u_if.rename_vregid;
            end
         end
      end
   endtask

   task automatic model_query(input logic [4:0] q, output logic b, output logic [4:0] v,
                              output logic [31:0] x);
      b = 1'b0; v = 5'd0; x = 32'd0;
      if (q == 5'd0) begin
         b = 1'b0;
      end else if (!m_busy[q]) begin
         x = m_val[q];
      end else if (u_if.writeback_en && u_if.writeback_id == q &&
                   u_if.writeback_dependency == m_tag[q]) begin
         x = u_if.writeback_val;
      end else begin
         b = 1'b1; v = m_tag[q]; x = m_val[q];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Compare one query port; vregid is only meaningful when busy or for r0.
   task automatic check_port(input string nm, input int p, input logic [4:0] q,
                             input logic eb, input logic [4:0] ev, input logic [31:0] ex,
                             input bit chk_v);
      logic        gb;
      logic [4:0]  gv;
      logic [31:0] gx;
      if (p == 1) begin
         gb = u_if.query_busy1; gv = u_if.query_vregid1; gx = u_if.query_val1;
      end else begin
         gb = u_if.query_busy2; gv = u_if.query_vregid2; gx = u_if.query_val2;
      end
      cmp($sformatf("%s.p%0d.r%0d.busy", nm, p, q), {31'd0, gb}, {31'd0, eb});
      cmp($sformatf("%s.p%0d.r%0d.val", nm, p, q), gx, ex);
      if (chk_v || eb || q == 5'd0)
         cmp($sformatf("%s.p%0d.r%0d.vregid", nm, p, q), {27'd0, gv}, {27'd0, ev});
   endtask

   function automatic logic [4:0] pick_id();
      int r;
      r = $urandom_range(0, 9);
      return (r == 9) ? 5'd31 : 5'(r);
   endfunction

   initial begin
      vec_t v;
      logic eb1, eb2;
      logic [4:0] ev1, ev2;
      logic [31:0] ex1, ex2;

      tbl[0]  = mk(0,0,0,0, 0,0,0,0,           5,31,  0,0,0,       0,0,0);
      tbl[1]  = mk(0,0,0,0, 1,0,0,'hDEAD,      0,0,   0,0,0,       0,0,0);
      tbl[2]  = mk(0,0,0,0, 0,0,0,0,           0,5,   0,0,0,       0,0,0);
      tbl[3]  = mk(0,1,3,7, 0,0,0,0,           3,0,   0,0,0,       0,0,0);
      tbl[4]  = mk(0,0,0,0, 0,0,0,0,           3,0,   1,7,0,       0,0,0);
      tbl[5]  = mk(0,0,0,0, 1,3,7,'h1234,      3,3,   0,0,'h1234,  0,0,'h1234);
      tbl[6]  = mk(0,0,0,0, 0,0,0,0,           3,0,   0,0,'h1234,  0,0,0);
      tbl[7]  = mk(0,1,4,2, 0,0,0,0,           4,3,   0,0,0,       0,0,'h1234);
      tbl[8]  = mk(0,1,4,9, 0,0,0,0,           4,0,   1,2,0,       0,0,0);
      tbl[9]  = mk(0,0,0,0, 1,4,2,'h55,        4,0,   1,9,0,       0,0,0);
      tbl[10] = mk(0,0,0,0, 0,0,0,0,           4,0,   1,9,'h55,    0,0,0);
      tbl[11] = mk(0,0,0,0, 1,4,9,'h66,        4,0,   0,0,'h66,    0,0,0);
      tbl[12] = mk(0,0,0,0, 0,0,0,0,           4,0,   0,0,'h66,    0,0,0);
      tbl[13] = mk(0,1,6,1, 0,0,0,0,           6,0,   0,0,0,       0,0,0);
      tbl[14] = mk(0,1,6,12,1,6,1,'hA,         6,0,   0,0,'hA,     0,0,0);
      tbl[15] = mk(0,0,0,0, 0,0,0,0,           6,0,   1,12,'hA,    0,0,0);
      tbl[16] = mk(0,1,1,3, 1,2,0,'h22,        1,2,   0,0,0,       0,0,0);
      tbl[17] = mk(0,1,2,4, 0,0,0,0,           1,2,   1,3,0,       0,0,'h22);
      tbl[18] = mk(1,1,8,5, 1,1,3,'h77,        1,2,   0,0,'h77,    1,4,'h22);
      tbl[19] = mk(0,0,0,0, 0,0,0,0,           1,2,   0,0,'h77,    0,0,'h22);
      tbl[20] = mk(0,0,0,0, 0,0,0,0,           8,6,   0,0,0,       0,0,'hA);
      tbl[21] = mk(0,0,0,0, 1,10,0,'h20,       10,0,  0,0,0,       0,0,0);
      tbl[22] = mk(0,1,10,15,0,0,0,0,          10,0,  0,0,'h20,    0,0,0);
      tbl[23] = mk(0,0,0,0, 0,0,0,0,           10,0,  1,15,'h20,   0,0,0);
      tbl[24] = mk(0,1,0,7, 0,0,0,0,           0,10,  0,0,0,       1,15,'h20);
      tbl[25] = mk(0,0,0,0, 0,0,0,0,           0,10,  0,0,0,       1,15,'h20);
      tbl[26] = mk(0,0,0,0, 0,10,15,'h99,      10,0,  1,15,'h20,   0,0,0);
      tbl[27] = mk(0,1,31,31,0,0,0,0,          31,0,  0,0,0,       0,0,0);
      tbl[28] = mk(0,0,0,0, 0,0,0,0,           31,0,  1,31,0,      0,0,0);
      tbl[29] = mk(0,0,0,0, 1,31,31,'hFFFFFFFF,31,0,  0,0,'hFFFFFFFF,0,0,0);

      // reset for two cycles with idle inputs
      rst = 1'b1;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // directed vectors: expected values are the same-cycle query results
      for (int i = 0; i < 30; i++) begin
         drive(tbl[i]);
         #1;
         check_port($sformatf("vec%0d", i), 1, tbl[i].q1, tbl[i].eb1, tbl[i].ev1, tbl[i].ex1, 1'b0);
         check_port($sformatf("vec%0d", i), 2, tbl[i].q2, tbl[i].eb2, tbl[i].ev2, tbl[i].ex2, 1'b0);
         tick();
      end

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
         v.fl  = ($urandom_range(0, 15) == 0);
         v.re  = ($urandom_range(0, 1) == 1);
         v.rid = pick_id();
         v.rv  = 5'($urandom);
         v.we  = ($urandom_range(0, 1) == 1);
         v.wid = pick_id();
         v.wd  = ($urandom_range(0, 3) != 0) ? m_tag[v.wid] : 5'($urandom);
         v.wv  = $urandom;
         v.q1  = ($urandom_range(0, 2) == 0) ? v.wid : pick_id();
         v.q2  = ($urandom_range(0, 2) == 0) ? v.rid : pick_id();
         drive(v);
         #1;
         model_query(v.q1, eb1, ev1, ex1);
         model_query(v.q2, eb2, ev2, ex2);
         check_port($sformatf("rnd%0d", n), 1, v.q1, eb1, ev1, ex1, 1'b0);
         check_port($sformatf("rnd%0d", n), 2, v.q2, eb2, ev2, ex2, 1'b0);
         tick();
      end

      // reset wins over a simultaneous flush, rename and commit
      rst = 1'b1;
      drive(mk(1,1,5,9,1,5,0,'h1111,0,0,0,0,0,0,0,0));
      tick();
      rst = 1'b0;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      for (int r = 1; r < 32; r++) begin
         u_if.query_regid1 = 5'(r);
         u_if.query_regid2 = 5'(32 - r);
         #1;
         check_port("post_rst", 1, 5'(r), 1'b0, 5'd0, 32'd0, 1'b1);
         check_port("post_rst", 2, 5'(32 - r), 1'b0, 5'd0, 32'd0, 1'b1);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
